// File: rtl/uart_tx_fifo_drain.sv
// rtl/uart_tx_fifo_drain.sv - FIFO-draining UART transmitter, 8N1/8N2 (8E1/8E2 with UART_TX_PARITY_EN)
// Pops a byte whenever the FIFO is non-empty and the line is free; back-to-back frames have no idle gap.
module uart_tx_fifo_drain #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD      = 9600,
  parameter int STOP_BITS = 1
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iTxEn,
  input  logic       iEmpty,
  input  logic [7:0] iRdData,
  output logic       oPop,
  output logic       oTx,
  output logic       oBusy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3
`ifdef UART_TX_PARITY_EN
    , PARITY = 3'd4
`endif
  } state_t;

  state_t          state, nstate;
  logic [CW-1:0]   baud_cnt, nbaud;
  logic [2:0]      bit_cnt, nbit;
  logic            stop_cnt, nstop;
  logic [7:0]      shift, nshift;
  logic            tx, ntx;
  logic            bit_end, last_stop, pop;
`ifdef UART_TX_PARITY_EN
  logic            par, npar;
`endif

  assign bit_end   = (baud_cnt == BAUD_LAST);
  assign last_stop = (state == STOP) && bit_end && (stop_cnt == STOP_LAST);
  // Reset masks the pop so a byte is never consumed while the transmitter is being cleared.
  assign pop   = ~iRst & iTxEn & ~iEmpty & ((state == IDLE) | last_stop);
  assign oPop  = pop;
  assign oBusy = ~iRst & ((state != IDLE) | pop);
  assign oTx   = tx;

  always_comb begin
    nstate = state;
    nbaud  = baud_cnt;
    nbit   = bit_cnt;
    nstop  = stop_cnt;
    nshift = shift;
`ifdef UART_TX_PARITY_EN
    npar   = par;
`endif
    if (pop) begin
      nstate = START;
      nbaud  = '0;
      nbit   = '0;
      nstop  = 1'b0;
      nshift = iRdData;
`ifdef UART_TX_PARITY_EN
      npar   = ^iRdData;
`endif
    end else begin
      nbaud = bit_end ? '0 : baud_cnt + CW'(1);
      case (state)
        IDLE:  nbaud = '0;
        START: if (bit_end) nstate = DATA;
        DATA: begin
          if (bit_end) begin
            nshift = {1'b0, shift[7:1]};
            nbit   = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              nstate = PARITY;
`else
              nstate = STOP;
`endif
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: if (bit_end) nstate = STOP;
`endif
        STOP: begin
          if (bit_end) begin
            if (stop_cnt == STOP_LAST) begin
              nstate = IDLE;
              nstop  = 1'b0;
            end else begin
              nstop = 1'b1;
            end
          end
        end
        default: nstate = IDLE;
      endcase
    end
  end

  // Line level is derived from the next state so oTx comes straight from a flop.
  always_comb begin
    ntx = 1'b1;
    case (nstate)
      START: ntx = 1'b0;
      DATA:  ntx = nshift[0];
`ifdef UART_TX_PARITY_EN
      PARITY: ntx = npar;
`endif
      default: ntx = 1'b1;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      shift    <= '0;
      tx       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      state    <= nstate;
      baud_cnt <= nbaud;
      bit_cnt  <= nbit;
      stop_cnt <= nstop;
      shift    <= nshift;
      tx       <= ntx;
`ifdef UART_TX_PARITY_EN
      par      <= npar;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// tb/tb_uart_tx_fifo_drain.sv - directed bench for uart_tx_fifo_drain at 10 clocks per bit
// Honours UART_TX_PARITY_EN to expect 8E1 frames instead of 8N1.
module tb_uart_tx_fifo_drain;

`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int CPB = 10;

  logic       iClk = 1'b0;
  logic       iRst, iTxEn, iEmpty;
  logic [7:0] iRdData;
  logic       oPop, oTx, oBusy;

  uart_tx_fifo_drain #(.CLK_FREQ(1000), .BAUD(100), .STOP_BITS(1)) dut (
    .iClk(iClk), .iRst(iRst), .iTxEn(iTxEn), .iEmpty(iEmpty),
    .iRdData(iRdData), .oPop(oPop), .oTx(oTx), .oBusy(oBusy)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // 8N1 line levels, bit 0 = start bit first on the wire
    logic       par;
  } vec_t;

  vec_t       vecs[7];
  logic [7:0] q[$];
  logic       s_pop, s_tx, s_busy;
  int         tests = 0, fails = 0;
  int         pop_count = 0, pop_empty = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sync_fifo();
    iEmpty  = (q.size() == 0);
    iRdData = iEmpty ? 8'h00 : q[0];
  endtask

  task automatic push(input logic [7:0] d);
    q.push_back(d);
    sync_fifo();
  endtask

  task automatic tick();
    @(negedge iClk);
    s_pop  = oPop;
    s_tx   = oTx;
    s_busy = oBusy;
    @(posedge iClk);
    #1;
    if (s_pop) begin
      pop_count++;
      if (q.size() == 0) pop_empty++;
      else void'(q.pop_front());
    end
    sync_fifo();
  endtask

  task automatic wait_pop(input string name);
    logic got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = s_pop;
    end
    chk(name, got, 1'b1);
    chk({name, " busy"}, s_busy, 1'b1);
  endtask

  // Current cycle must be the pop cycle; consumes the NB*CPB cycles of the frame.
  task automatic check_frame(input vec_t v, output logic last_pop);
    logic [NB-1:0] expv;
    logic          act;
    int            busy_n = 0, stray = 0;
    for (int b = 0; b < 9; b++) expv[b] = v.frame[b];
`ifdef UART_TX_PARITY_EN
    expv[9]  = v.par;
    expv[10] = 1'b1;
`else
    expv[9]  = v.frame[9];
`endif
    for (int b = 0; b < NB; b++) begin
      act = expv[b];
      for (int c = 0; c < CPB; c++) begin
        tick();
        if (s_tx !== expv[b]) act = s_tx;
        if (s_busy === 1'b1) busy_n++;
        if (s_pop && !(b == NB - 1 && c == CPB - 1)) stray++;
      end
      chk($sformatf("frame %02h bit %0d", v.data, b), act, expv[b]);
    end
    chk($sformatf("frame %02h busy cycles", v.data), busy_n, NB * CPB);
    chk($sformatf("frame %02h stray pops", v.data), stray, 0);
    last_pop = s_pop;
  endtask

  task automatic check_idle(input string name);
    tick();
    chk({name, " idle tx"}, s_tx, 1'b1);
    chk({name, " idle busy"}, s_busy, 1'b0);
    chk({name, " idle pop"}, s_pop, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
    $fatal(1);
  end

  initial begin
    logic lp;
    int   base;
    logic all_high;

    vecs[0] = '{8'hA5, 10'b1_10100101_0, 1'b0};
    vecs[1] = '{8'h00, 10'b1_00000000_0, 1'b0};
    vecs[2] = '{8'hFF, 10'b1_11111111_0, 1'b0};
    vecs[3] = '{8'h3C, 10'b1_00111100_0, 1'b0};
    vecs[4] = '{8'h07, 10'b1_00000111_0, 1'b1};
    vecs[5] = '{8'h03, 10'b1_00000011_0, 1'b0};
    vecs[6] = '{8'h55, 10'b1_01010101_0, 1'b0};

    iRst  = 1'b1;
    iTxEn = 1'b1;
    sync_fifo();
    push(8'hA5);
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("reset pop %0d", i), s_pop, 1'b0);
      chk($sformatf("reset tx %0d", i), s_tx, 1'b1);
      chk($sformatf("reset busy %0d", i), s_busy, 1'b0);
    end
    iRst = 1'b0;
    tick();
    chk("first pop after reset", s_pop, 1'b1);
    chk("first pop busy", s_busy, 1'b1);
    check_frame(vecs[0], lp);
    chk("single last pop", lp, 1'b0);
    check_idle("single");

    for (int i = 1; i < 6; i++) begin
      push(vecs[i].data);
      wait_pop($sformatf("vec %0d pop", i));
      check_frame(vecs[i], lp);
      chk($sformatf("vec %0d last pop", i), lp, 1'b0);
      check_idle($sformatf("vec %0d", i));
    end

    base = pop_count;
    push(8'h00);
    push(8'hFF);
    push(8'h3C);
    wait_pop("burst pop");
    for (int k = 0; k < 3; k++) begin
      check_frame(vecs[k + 1], lp);
      chk($sformatf("burst chained pop %0d", k), lp, (k < 2) ? 1'b1 : 1'b0);
    end
    chk("burst pop count", pop_count - base, 3);
    check_idle("burst");

    base = pop_count;
    all_high = 1'b1;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (s_tx !== 1'b1) all_high = 1'b0;
    end
    chk("empty no pop", pop_count - base, 0);
    chk("empty tx high", all_high, 1'b1);
    iTxEn = 1'b0;
    push(8'h3C);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (s_tx !== 1'b1) all_high = 1'b0;
    end
    chk("disabled no pop", pop_count - base, 0);
    chk("disabled tx high", all_high, 1'b1);
    iTxEn = 1'b1;
    tick();
    chk("enable pop", s_pop, 1'b1);
    check_frame(vecs[3], lp);
    check_idle("enable");

    base = pop_count;
    push(8'h55);
    push(8'hA5);
    wait_pop("midreset pop");
    for (int i = 0; i < 55; i++) tick();
    chk("midreset data bit4", s_tx, 1'b1);
    iRst = 1'b1;
    tick();
    chk("midreset pop during reset", s_pop, 1'b0);
    iRst = 1'b0;
    tick();
    chk("midreset tx after reset", s_tx, 1'b1);
    chk("midreset next pop", s_pop, 1'b1);
    chk("midreset pop count", pop_count - base, 2);
    check_frame(vecs[0], lp);
    check_idle("midreset");

    chk("pop while empty", pop_empty, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
